// File: rtl/mouse_sequence_decoder.sv
// Pulls 4-byte mouse reports (0x1E, modifier, x, y) out of a byte stream;
// every other byte, and any broken report, goes out unchanged and in order.
module mouse_sequence_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_in_valid,
  output logic       byte_in_ready,
  output logic [7:0] byte_out,
  output logic       byte_out_valid,
  input  logic       byte_out_ready,
  output logic       event_valid,
  output logic       button_left,
  output logic       button_right,
  output logic       button_middle,
  output logic       key_shift,
  output logic       key_ctrl,
  output logic       key_alt,
  output logic       key_meta,
  output logic [6:0] x_text,
  output logic [5:0] y_text,
  output logic       seq_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_MOD   = 3'd2;
  localparam logic [2:0] S_XB    = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  localparam logic [7:0] HDR_BYTE = 8'h1E;
  localparam logic [TIMEOUT_WIDTH-1:0] TO_MAX =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  logic [2:0]               state;
  logic [TIMEOUT_WIDTH-1:0] tcnt;
  // Entries 0..2 hold the report so far, entry 3 the pending byte.
  logic [7:0]               rbuf [4];
  logic [1:0]               rcnt;
  logic [1:0]               fidx;
  logic                     pend;

  logic out_free;
  logic accept;
  logic in_report;
  logic timeout;
  logic bad_byte;
  logic last_flush;

  always_comb begin
    out_free      = !byte_out_valid || byte_out_ready;
    byte_in_ready = reset && (state != S_FLUSH) && out_free;
    accept        = byte_in_valid && byte_in_ready;
    in_report     = (state == S_HDR) || (state == S_MOD) ||
                    (state == S_XB);
    timeout       = in_report && !accept && (tcnt == TO_MAX);
    bad_byte      = (state == S_XB) ? (byte_in[7:6] != 2'b10)
                                    : !byte_in[7];
    last_flush    = (fidx == rcnt - 2'd1);
  end

  // Inter-byte timer: runs only inside a report, saturates at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (!in_report || accept) begin
      tcnt <= '0;
    end else if (tcnt != TO_MAX) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      for (int i = 0; i < 4; i++) rbuf[i] <= '0;
      rcnt           <= '0;
      fidx           <= '0;
      pend           <= 1'b0;
      byte_out       <= '0;
      byte_out_valid <= 1'b0;
      event_valid    <= 1'b0;
      seq_error      <= 1'b0;
      button_left    <= 1'b0;
      button_right   <= 1'b0;
      button_middle  <= 1'b0;
      key_shift      <= 1'b0;
      key_ctrl       <= 1'b0;
      key_alt        <= 1'b0;
      key_meta       <= 1'b0;
      x_text         <= '0;
      y_text         <= '0;
    end else begin
      event_valid <= 1'b0;
      seq_error   <= 1'b0;
      if (byte_out_valid && byte_out_ready) begin
        byte_out_valid <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (byte_in == HDR_BYTE) begin
              rbuf[0] <= byte_in;
              rcnt    <= 2'd1;
              state   <= S_HDR;
            end else begin
              byte_out       <= byte_in;
              byte_out_valid <= 1'b1;
            end
          end
        end

        S_HDR, S_MOD, S_XB: begin
          if (accept && bad_byte) begin
            seq_error <= 1'b1;
            rbuf[3]   <= byte_in;
            pend      <= 1'b1;
            fidx      <= '0;
            state     <= S_FLUSH;
          end else if (accept && state == S_XB) begin
            {key_meta, key_alt, key_ctrl, key_shift,
             button_middle, button_right, button_left} <= rbuf[1][6:0];
            x_text      <= rbuf[2][6:0];
            y_text      <= byte_in[5:0];
            event_valid <= 1'b1;
            rcnt        <= '0;
            state       <= S_IDLE;
          end else if (accept) begin
            rbuf[rcnt] <= byte_in;
            rcnt       <= rcnt + 2'd1;
            state      <= (state == S_HDR) ? S_MOD : S_XB;
          end else if (timeout) begin
            seq_error <= 1'b1;
            pend      <= 1'b0;
            fidx      <= '0;
            state     <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (out_free) begin
            if (fidx != rcnt) begin
              byte_out       <= rbuf[fidx];
              byte_out_valid <= 1'b1;
              fidx           <= fidx + 2'd1;
              if (last_flush && !pend) begin
                rcnt  <= '0;
                state <= S_IDLE;
              end
            end else begin
              // Pending byte is handled exactly as a fresh IDLE arrival.
              pend <= 1'b0;
              fidx <= '0;
              if (rbuf[3] == HDR_BYTE) begin
                rbuf[0] <= rbuf[3];
                rcnt    <= 2'd1;
                state   <= S_HDR;
              end else begin
                byte_out       <= rbuf[3];
                byte_out_valid <= 1'b1;
                rcnt           <= '0;
                state          <= S_IDLE;
              end
            end
          end
        end

        default: begin
          rcnt  <= '0;
          pend  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
